// File: rtl/store_buffer.sv
// Store buffer between the MEM-stage pipeline register and the single-port data memory.
// Stores are queued in a circular FIFO and retired to memory in program order during
// cycles in which the pipeline leaves the memory port free. Loads forward from the
// youngest matching buffered store, otherwise read memory directly.
module store_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cpu_mem_read,
  input  logic                       cpu_mem_write,
  input  logic [ADDR_W-1:0]          cpu_address,
  input  logic [DATA_W-1:0]          cpu_write_data,
  output logic [DATA_W-1:0]          cpu_read_data,
  output logic                       stall,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic [ADDR_W-1:0]          mem_address,
  output logic [DATA_W-1:0]          mem_write_data,
  input  logic [DATA_W-1:0]          mem_read_data,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = $clog2(DEPTH+1);
  localparam int unsigned WordW = ADDR_W - 2;

  // Entry storage; contents need no reset because count gates validity.
  logic [WordW-1:0]  addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;

  logic              is_store;
  logic              is_load;
  logic              is_idle;
  logic              full;
  logic              enq;
  logic              drain;
  logic              hit;
  logic [DATA_W-1:0] hit_data;
  logic [PtrW-1:0]   idx;

  // Request decode: a write wins over a simultaneous read.
  always_comb begin
    is_store = cpu_mem_write;
    is_load  = cpu_mem_read & ~cpu_mem_write;
    is_idle  = ~cpu_mem_read & ~cpu_mem_write;
    full     = (count_q == CntW'(DEPTH));
    empty    = (count_q == '0);
    stall    = is_store & full;
    enq      = is_store & ~full;
    // Draining only in idle or stalled cycles keeps it exclusive with enqueue and loads.
    drain    = ~empty & (is_idle | stall);
    count    = count_q;
  end

  // Forwarding search from oldest to youngest so the youngest match wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PtrW'(i);
      if ((CntW'(i) < count_q) && (addr_q[idx] == cpu_address[ADDR_W-1:2])) begin
        hit      = 1'b1;
        hit_data = data_q[idx];
      end
    end
  end

  // Memory port and load result steering.
  always_comb begin
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    cpu_read_data  = '0;
    if (drain) begin
      mem_write      = 1'b1;
      mem_address    = {addr_q[head_q], 2'b00};
      mem_write_data = data_q[head_q];
    end else if (is_load) begin
      if (hit) begin
        cpu_read_data = hit_data;
      end else begin
        mem_read      = 1'b1;
        mem_address   = cpu_address;
        cpu_read_data = mem_read_data;
      end
    end
  end

  // Pointer and occupancy next-state.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq) begin
      tail_d  = tail_q + PtrW'(1);
      count_d = count_q + CntW'(1);
    end else if (drain) begin
      head_d  = head_q + PtrW'(1);
      count_d = count_q - CntW'(1);
    end
  end

  // Pointer and occupancy registers; reset discards every pending store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Capture an accepted store at the tail slot.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q] <= cpu_address[ADDR_W-1:2];
      data_q[tail_q] <= cpu_write_data;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Randomized and directed bench for store_buffer against a queue-based reference model.
module tb_store_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CntW  = $clog2(DEPTH+1);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cpu_mem_read = 1'b0;
  logic            cpu_mem_write = 1'b0;
  logic [31:0]     cpu_address = '0;
  logic [31:0]     cpu_write_data = '0;
  logic [31:0]     cpu_read_data;
  logic            stall;
  logic            mem_read;
  logic            mem_write;
  logic [31:0]     mem_address;
  logic [31:0]     mem_write_data;
  logic [31:0]     mem_read_data = '0;
  logic            empty;
  logic [CntW-1:0] count;

  store_buffer #(
    .DEPTH (DEPTH),
    .ADDR_W(32),
    .DATA_W(32)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cpu_mem_read  (cpu_mem_read),
    .cpu_mem_write (cpu_mem_write),
    .cpu_address   (cpu_address),
    .cpu_write_data(cpu_write_data),
    .cpu_read_data (cpu_read_data),
    .stall         (stall),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_write_data(mem_write_data),
    .mem_read_data (mem_read_data),
    .empty         (empty),
    .count         (count)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: an ordered queue of pending stores plus a word-addressed memory.
  typedef struct packed {
    logic [29:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  logic [31:0] mem_m [bit [29:0]];

  function automatic logic [31:0] mem_rd(input logic [29:0] w);
    if (mem_m.exists(w)) return mem_m[w];
    return 32'h5A5A0000 ^ {2'b00, w};
  endfunction

  // Decisions of the current cycle, kept for the commit step.
  bit          m_store;
  bit          m_stall;
  bit          m_drain;
  logic [31:0] m_addr;
  logic [31:0] m_data;

  // Apply a request, let memory respond, and compare every output with the model.
  task automatic drive(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    bit          ld;
    bit          idle;
    bit          hit;
    logic [31:0] hd;
    logic [31:0] e_rd;
    logic [31:0] e_ma;
    logic [31:0] e_md;
    bit          e_mr;
    @(negedge clk);
    cpu_mem_read   = r;
    cpu_mem_write  = w;
    cpu_address    = a;
    cpu_write_data = d;
    #1;
    mem_read_data = mem_rd(mem_address[31:2]);
    #1;
    m_store = w;
    m_addr  = a;
    m_data  = d;
    ld      = r && !w;
    idle    = !r && !w;
    m_stall = w && (q.size() == DEPTH);
    m_drain = (q.size() != 0) && (idle || m_stall);
    hit     = 1'b0;
    hd      = '0;
    foreach (q[i]) begin
      if (q[i].a == a[31:2]) begin
        hit = 1'b1;
        hd  = q[i].d;
      end
    end
    e_mr = ld && !hit;
    e_rd = !ld ? 32'h0 : (hit ? hd : mem_rd(a[31:2]));
    e_ma = m_drain ? {q[0].a, 2'b00} : (e_mr ? a : 32'h0);
    e_md = m_drain ? q[0].d : 32'h0;
    check("stall", {31'b0, stall}, {31'b0, m_stall});
    check("mem_write", {31'b0, mem_write}, {31'b0, m_drain});
    check("mem_read", {31'b0, mem_read}, {31'b0, e_mr});
    check("mem_address", mem_address, e_ma);
    check("mem_write_data", mem_write_data, e_md);
    check("cpu_read_data", cpu_read_data, e_rd);
    check("count", 32'(count), 32'(q.size()));
    check("empty", {31'b0, empty}, {31'b0, q.size() == 0});
  endtask

  // Advance the model to the state after the coming rising edge.
  task automatic commit();
    ent_t e;
    if (m_drain) begin
      mem_m[q[0].a] = q[0].d;
      void'(q.pop_front());
    end
    if (m_store && !m_stall) begin
      e.a = m_addr[31:2];
      e.d = m_data;
      q.push_back(e);
    end
  endtask

  task automatic cyc(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    drive(r, w, a, d);
    commit();
  endtask

  task automatic drain_all();
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (q.size() != 0) cyc(1'b0, 1'b0, 32'h0, 32'h0);
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rd;
    bit          pend;
    int unsigned op;

    // Reset state.
    #3;
    check("rst_count", 32'(count), 32'h0);
    check("rst_empty", {31'b0, empty}, 32'h1);
    check("rst_mem_write", {31'b0, mem_write}, 32'h0);
    check("rst_mem_addr", mem_address, 32'h0);
    check("rst_rd", cpu_read_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset asserted with three stores pending.
    cyc(1'b0, 1'b1, 32'h40, 32'h11111111);
    cyc(1'b0, 1'b1, 32'h44, 32'h22222222);
    cyc(1'b0, 1'b1, 32'h48, 32'h33333333);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_count", 32'(count), 32'h0);
    check("midrst_empty", {31'b0, empty}, 32'h1);
    check("midrst_mem_write", {31'b0, mem_write}, 32'h0);
    check("midrst_mem_addr", mem_address, 32'h0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 32'h0, 32'h0);

    // Forwarding from a store one cycle later.
    cyc(1'b0, 1'b1, 32'h10, 32'hA5A5A5A5);
    drive(1'b1, 1'b0, 32'h12, 32'h0);
    check("fwd_data", cpu_read_data, 32'hA5A5A5A5);
    check("fwd_mem_read", {31'b0, mem_read}, 32'h0);
    commit();
    drain_all();

    // Youngest match wins; both stores still retire in order.
    cyc(1'b0, 1'b1, 32'h20, 32'h1);
    cyc(1'b0, 1'b1, 32'h20, 32'h2);
    drive(1'b1, 1'b0, 32'h20, 32'h0);
    check("young_data", cpu_read_data, 32'h2);
    commit();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check("young_w1_addr", mem_address, 32'h20);
    check("young_w1_data", mem_write_data, 32'h1);
    commit();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check("young_w2_addr", mem_address, 32'h20);
    check("young_w2_data", mem_write_data, 32'h2);
    commit();
    drain_all();

    // Full buffer stalls one cycle while the head drains.
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 32'(i * 4), 32'h100 + 32'(i));
    drive(1'b0, 1'b1, 32'h10, 32'h200);
    check("full_stall", {31'b0, stall}, 32'h1);
    check("full_mem_write", {31'b0, mem_write}, 32'h1);
    check("full_addr", mem_address, 32'h0);
    check("full_data", mem_write_data, 32'h100);
    commit();
    drive(1'b0, 1'b1, 32'h10, 32'h200);
    check("full_nostall", {31'b0, stall}, 32'h0);
    commit();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      if (i == 0) check("full_count", 32'(count), 32'h4);
      check("idle_drain_addr", mem_address, 32'(4 + i * 4));
      commit();
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check("drained_empty", {31'b0, empty}, 32'h1);
    commit();
    drive(1'b1, 1'b0, 32'h8, 32'h0);
    check("miss_mem_read", {31'b0, mem_read}, 32'h1);
    check("miss_data", cpu_read_data, 32'h102);
    commit();

    // Read and write together act as a store.
    drive(1'b1, 1'b1, 32'h30, 32'h7);
    check("rw_rd", cpu_read_data, 32'h0);
    check("rw_mem_read", {31'b0, mem_read}, 32'h0);
    commit();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check("rw_count", 32'(count), 32'h1);
    check("rw_data", mem_write_data, 32'h7);
    commit();

    // Random traffic over a small address window; a stalled store is held and retried.
    pend = 1'b0;
    ra   = '0;
    rd   = '0;
    for (int n = 0; n < 600; n++) begin
      if (pend) begin
        cyc(1'b0, 1'b1, ra, rd);
        pend = m_stall;
      end else begin
        op = $urandom_range(0, 7);
        ra = 32'h100 + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(0, 3));
        rd = $urandom;
        if (op < 4) begin
          cyc(1'b0, 1'b1, ra, rd);
          pend = m_stall;
        end else if (op < 6) begin
          cyc(1'b1, 1'b0, ra, 32'h0);
        end else if (op == 6) begin
          cyc(1'b1, 1'b1, ra, rd);
          pend = m_stall;
        end else begin
          cyc(1'b0, 1'b0, 32'h0, 32'h0);
        end
      end
    end
    drain_all();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Word-granular FIFO store buffer between the MEM-stage pipeline register and the single-port data memory of the pipelined core. It queues stores and retires them to memory in program order whenever the pipeline leaves the memory port idle. Loads are serviced from the youngest matching buffered store, or from memory on a miss. The pipeline is stalled only when a store arrives while the buffer is full.

## Interface
- DEPTH, 4: number of buffered stores; a power of two, at least 2.
- ADDR_W, 32: byte address width.
- DATA_W, 32: data word width.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_mem_read  in  1  MEM-stage load request.
- cpu_mem_write  in  1  MEM-stage store request.
- cpu_address  in  ADDR_W  byte address; bits [1:0] ignored.
- cpu_write_data  in  DATA_W  store data.
- cpu_read_data  out  DATA_W  load result (combinational).
- stall  out  1  freezes PC and pipeline registers this cycle (combinational).
- mem_read  out  1  data memory read enable.
- mem_write  out  1  data memory write enable.
- mem_address  out  ADDR_W  data memory byte address.
- mem_write_data  out  DATA_W  data memory write data.
- mem_read_data  in  DATA_W  combinational read data from memory.
- empty  out  1  no pending stores.
- count  out  $clog2(DEPTH+1)  number of pending stores.

## Operation
- State: circular array of {word address [ADDR_W-1:2], data}, head pointer, tail pointer, count. Pointers wrap modulo DEPTH.
- Request decode: if cpu_mem_write=1, the cycle is a store, and cpu_mem_read is ignored (cpu_read_data=0). If only cpu_mem_read=1, the cycle is a load. If neither is set, the cycle is idle.
- stall = cpu_mem_write & (count==DEPTH).
- Enqueue: store & !stall writes the entry at tail, then tail+1 and count+1.
- Drain: drain = !empty & (idle | stall). When drain=1: mem_write=1, mem_address={head addr,2'b00}, mem_write_data=head data; at the edge, head+1 and count-1.
- Enqueue and drain are mutually exclusive in the same cycle, because a drain happens only when the cycle is idle or stalled.
- Load hit: if any valid entry matches cpu_address[ADDR_W-1:2], cpu_read_data = data of the youngest match (closest to tail), and mem_read=0.
- Load miss: mem_read=1, mem_address=cpu_address, cpu_read_data=mem_read_data.
- No load, or a store cycle: cpu_read_data=0.
- Default memory outputs: whenever mem_read=0 and mem_write=0, mem_address=0 and mem_write_data=0.
- Repeated stores to the same word are not coalesced. Each store occupies its own entry and is written to memory in order.

## Timing
- Reset (rst_n low, asynchronous): head=tail=count=0, empty=1, stall=0, mem_read=mem_write=0, mem_address=mem_write_data=0, cpu_read_data=0. Pending stores are discarded.
- Reset released mid-operation: the buffer starts empty. Discarded stores never reach memory.
- Store latency: a store presented in cycle k is captured at the end of cycle k. From cycle k+1 it is visible for forwarding. Its earliest memory write is cycle k+1 (committed at the end of k+1), if it is at the head and that cycle is idle.
- Load latency: zero cycles. The result is valid in the same cycle, on both hit and miss.
- Full store: stall=1 for exactly one cycle. In that cycle the head drains, so the store is accepted in the next cycle, with the pipeline still holding it.
- Load hitting the head entry: forwards from the buffer. No drain occurs, because the cycle is not idle.
- count saturates at DEPTH; an enqueue while full never occurs. A drain while empty never occurs.

## Test plan
- Reset with stores pending: drop rst_n mid-cycle with count=3 -> count=0, empty=1, mem_write=0 immediately; no later memory write of the old data.
- Forward: store 0x10<-0xA5A5A5A5, then load 0x12 next cycle -> cpu_read_data=0xA5A5A5A5, mem_read=0.
- Youngest match: stores 0x20<-1 and 0x20<-2 back-to-back, then load 0x20 -> 2. Then 2 idle cycles -> memory writes 1 then 2 at address 0x20.
- Full stall: stores to 0x0, 0x4, 0x8, 0xC, then a store to 0x10 -> stall=1 one cycle with mem_write=1 to 0x0, data of the first store. The next cycle stall=0, 0x10 is enqueued, and count=4.
- Idle drain then miss: after the full test, 4 idle cycles -> writes to 0x4, 0x8, 0xC, 0x10 in order, then empty=1. Then load 0x8 -> mem_read=1, cpu_read_data equals the memory word.
- Read+write same cycle: cpu_mem_read=cpu_mem_write=1 with address 0x30, data 7 -> treated as a store: cpu_read_data=0, entry enqueued, mem_read=0.
